// File: rtl/gpu_vram_arbiter_if.sv
// gpu_vram_arbiter_if: GPU read port, CPU port and single VRAM port of the VRAM arbiter.
// gpu_mode/gpu_req/gpu_addr -> gpu_ack/gpu_valid/gpu_data; cpu_req/cpu_we/cpu_addr/cpu_wdata ->
// cpu_ack/cpu_valid/cpu_data; mem_en/mem_we/mem_addr/mem_wdata to VRAM, mem_rdata from VRAM.
// master = clients and VRAM side, slave = arbiter side.
interface gpu_vram_arbiter_if #(parameter int ADDR_W = 13);
  logic [1:0] gpu_mode;
  logic gpu_req;
  logic [15:0] gpu_addr;
  logic gpu_ack;
  logic gpu_valid;
  logic [7:0] gpu_data;
  logic cpu_req;
  logic cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic cpu_ack;
  logic cpu_valid;
  logic [7:0] cpu_data;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  modport master(
    output gpu_mode, gpu_req, gpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input gpu_ack, gpu_valid, gpu_data, cpu_ack, cpu_valid, cpu_data, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave(
    input gpu_mode, gpu_req, gpu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output gpu_ack, gpu_valid, gpu_data, cpu_ack, cpu_valid, cpu_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: single-port VRAM arbiter between GPU reads and CPU accesses with bounded GPU bursts.
// Ports: clk, rst_n (async active-low), bus (gpu_vram_arbiter_if.slave: GPU/CPU request ports and VRAM port).
// Define VRAM_LOCKOUT_EN to lock the CPU out of VRAM in mode 3 (forced ack, reads return 8'hFF).
module gpu_vram_arbiter #(
  parameter int GPU_BURST_MAX = 4,
  parameter int ADDR_W = 13
) (
  input logic clk,
  input logic rst_n,
  gpu_vram_arbiter_if.slave bus
);
  logic lock, at_max, cpu_elig, cpu_win, gpu_win, forced;
  logic [3:0] cnt;
  logic tag_gpu, tag_cpu, tag_forced;
  logic unused_ok;
`ifdef VRAM_LOCKOUT_EN
  assign lock = bus.gpu_mode == 2'd3;
  assign unused_ok = ^{bus.gpu_addr[15:ADDR_W], bus.cpu_addr[15:ADDR_W]};
`else
  assign lock = 1'b0;
  assign unused_ok = ^{bus.gpu_mode, bus.gpu_addr[15:ADDR_W], bus.cpu_addr[15:ADDR_W]};
`endif
  assign at_max = cnt == 4'(GPU_BURST_MAX);
  assign cpu_elig = bus.cpu_req && !lock;
  assign forced = bus.cpu_req && lock;
  assign cpu_win = cpu_elig && (!bus.gpu_req || at_max);
  assign gpu_win = bus.gpu_req && !cpu_win;
  // Grants are gated by reset only on the outputs so the flops never see rst_n as data.
  assign bus.gpu_ack = rst_n && gpu_win;
  assign bus.cpu_ack = rst_n && (cpu_win || forced);
  assign bus.mem_en = rst_n && (gpu_win || cpu_win);
  assign bus.mem_we = rst_n && cpu_win && bus.cpu_we;
  assign bus.mem_addr = !rst_n ? '0 : cpu_win ? bus.cpu_addr[ADDR_W-1:0] : gpu_win ? bus.gpu_addr[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = bus.mem_we ? bus.cpu_wdata : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 4'd0;
      tag_gpu <= 1'b0;
      tag_cpu <= 1'b0;
      tag_forced <= 1'b0;
    end else begin
      cnt <= (!cpu_elig || cpu_win) ? 4'd0 : (gpu_win && !at_max) ? cnt + 4'd1 : cnt;
      tag_gpu <= gpu_win;
      tag_cpu <= (cpu_win || forced) && !bus.cpu_we;
      tag_forced <= forced;
    end
  assign bus.gpu_valid = tag_gpu;
  assign bus.gpu_data = tag_gpu ? bus.mem_rdata : 8'h00;
  assign bus.cpu_valid = tag_cpu;
  assign bus.cpu_data = !tag_cpu ? 8'h00 : tag_forced ? 8'hFF : bus.mem_rdata;
endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// tb_gpu_vram_arbiter: scoreboard bench for gpu_vram_arbiter with a behavioural VRAM model.
module tb_gpu_vram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_vram_arbiter_if #(.ADDR_W(13)) bus();
  gpu_vram_arbiter #(.GPU_BURST_MAX(4), .ADDR_W(13)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] vram [0:8191];
  logic [7:0] gq[$];
  logic [7:0] cq[$];
  int checks = 0;
  int failures = 0;
`ifdef VRAM_LOCKOUT_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  always @(posedge clk) begin
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? vram[bus.mem_addr] : 8'h00;
    if (bus.mem_en && bus.mem_we) vram[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.gpu_valid) begin
      if (gq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL gpu_valid_unexpected: got data %0h want no valid", bus.gpu_data);
      end else chk("gpu_data", bus.gpu_data, gq.pop_front());
    end else chk("gpu_data_idle", bus.gpu_data, 0);
    if (bus.cpu_valid) begin
      if (cq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpu_valid_unexpected: got data %0h want no valid", bus.cpu_data);
      end else chk("cpu_data", bus.cpu_data, cq.pop_front());
    end else chk("cpu_data_idle", bus.cpu_data, 0);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic drain;
    for (int i = 0; i < 10 && (gq.size() != 0 || cq.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_pending", gq.size() + cq.size(), 0);
  endtask

  initial begin
    bus.gpu_mode = 2'd0;
    bus.gpu_req = 1'b0;
    bus.gpu_addr = 16'h0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0;
    bus.cpu_wdata = 8'h0;
    bus.mem_rdata = 8'h0;
    for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
    vram[16'h0010] = 8'h3C;
    vram[16'h0000] = 8'hA1;
    vram[16'h0001] = 8'hB2;
    vram[16'h0002] = 8'hC3;

    // reset held with both requests up
    step;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 16'h8010;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 16'h8001;
    sample;
    chk("rst_gpu_ack", bus.gpu_ack, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_valids", {bus.gpu_valid, bus.cpu_valid}, 0);
    step;
    bus.cpu_req = 1'b0;
    rst_n = 1'b1;
    gq.push_back(8'h3C);
    sample;
    chk("s1_gpu_ack", bus.gpu_ack, 1);
    chk("s1_mem_en", bus.mem_en, 1);
    chk("s1_mem_addr", bus.mem_addr, 13'h0010);
    step;
    bus.gpu_req = 1'b0;
    sample;
    chk("s1_gpu_valid", bus.gpu_valid, 1);

    // simultaneous requests: GPU first, CPU next cycle
    step;
    bus.gpu_mode = 2'd1;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 16'h8000;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h8001;
    gq.push_back(8'hA1);
    cq.push_back(8'hB2);
    sample;
    chk("s2_t0_acks", {bus.gpu_ack, bus.cpu_ack}, 2'b10);
    step;
    bus.gpu_req = 1'b0;
    sample;
    chk("s2_t1_acks", {bus.gpu_ack, bus.cpu_ack}, 2'b01);
    chk("s2_t1_gpu_valid", bus.gpu_valid, 1);
    step;
    bus.cpu_req = 1'b0;
    sample;
    chk("s2_t2_cpu_valid", bus.cpu_valid, 1);
    drain;

    // starvation bound: G G G G C G
    bus.gpu_mode = 2'd0;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 16'h8000;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 16'h8002;
    for (int i = 0; i < 5; i++) gq.push_back(8'hA1);
    cq.push_back(8'hC3);
    for (int i = 0; i < 6; i++) begin
      sample;
      chk($sformatf("s3_grant%0d", i), {bus.gpu_ack, bus.cpu_ack}, (i == 4) ? 2'b01 : 2'b10);
      if (i == 4) chk("s3_cnt_at_max", dut.cnt, 4);
      if (i == 5) chk("s3_cnt_cleared", dut.cnt, 0);
      step;
      if (i == 4) bus.cpu_req = 1'b0;
    end
    bus.gpu_req = 1'b0;
    drain;

    // mode 3 write: forced and dropped with lockout, real write without
    bus.gpu_mode = 2'd3;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h9800;
    bus.cpu_wdata = 8'h55;
    sample;
    chk("s4_w_ack", bus.cpu_ack, 1);
    chk("s4_w_mem_we", bus.mem_we, LOCK ? 0 : 1);
    chk("s4_w_mem_en", bus.mem_en, LOCK ? 0 : 1);
    if (!LOCK) chk("s4_w_addr_data", {bus.mem_addr, bus.mem_wdata}, {13'h1800, 8'h55});
    step;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    chk("s4_vram", vram[16'h1800], LOCK ? 8'h00 : 8'h55);
    sample;
    chk("s4_w_no_valid", bus.cpu_valid, 0);
    step;
    bus.cpu_req = 1'b1;
    cq.push_back(LOCK ? 8'hFF : 8'h55);
    sample;
    chk("s4_r_ack", bus.cpu_ack, 1);
    chk("s4_r_mem_en", bus.mem_en, LOCK ? 0 : 1);
    step;
    // mode leaves 3 one cycle after the previous ack: next read is real
    bus.gpu_mode = 2'd0;
    bus.cpu_addr = 16'h8001;
    cq.push_back(8'hB2);
    sample;
    chk("s5_r_ack", bus.cpu_ack, 1);
    chk("s5_r_mem_en", bus.mem_en, 1);
    step;
    bus.cpu_req = 1'b0;
    drain;
`ifdef VRAM_LOCKOUT_EN
    // forced CPU ack alongside a GPU grant
    bus.gpu_mode = 2'd3;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 16'h8010;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 16'h8001;
    gq.push_back(8'h3C);
    cq.push_back(8'hFF);
    sample;
    chk("s6_dual_ack", {bus.gpu_ack, bus.cpu_ack}, 2'b11);
    chk("s6_mem_addr", bus.mem_addr, 13'h0010);
    step;
    bus.gpu_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.gpu_mode = 2'd0;
    drain;
`endif

    // reset mid-access drops the pending response
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 16'h8010;
    sample;
    chk("s7_gpu_ack", bus.gpu_ack, 1);
    step;
    bus.gpu_req = 1'b0;
    rst_n = 1'b0;
    sample;
    chk("s7_no_valid", {bus.gpu_valid, bus.gpu_data}, 0);
    chk("s7_mem_en", bus.mem_en, 0);
    step;
    rst_n = 1'b1;
    bus.gpu_req = 1'b1;
    gq.push_back(8'h3C);
    sample;
    chk("s7_regrant", {bus.gpu_ack, bus.mem_addr}, {1'b1, 13'h0010});
    step;
    bus.gpu_req = 1'b0;
    drain;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
